alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 103 ++++++++++
 tb/tb_alu.sv | 139 +++++++++++++
 2 files changed

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- single-cycle integer ALU with a registered result.
//
// The result is formed combinationally from the operands and the operation
// select, then captured into BusW on every rising Clk edge (no enable, one
// cycle of latency). Zero is captured on the same edge and always reflects
// whether the registered result is all zeros.
//
// Ports
//   Clk     in   1       rising-edge clock
//   Resetb  in   1       asynchronous active-low reset (BusW=0, Zero=1)
//   BusA    in   DATA_W  operand A; low bits are the shift amount
//   BusB    in   DATA_W  operand B; shifted operand and LUI source
//   ALUCtrl in   4       operation select
//   BusW    out  DATA_W  registered result
//   Zero    out  1       registered (BusW == 0) flag
// ---------------------------------------------------------------------------
module alu #(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Resetb,
  input  logic [DATA_W-1:0] BusA,
  input  logic [DATA_W-1:0] BusB,
  input  logic [3:0]        ALUCtrl,
  output logic [DATA_W-1:0] BusW,
  output logic              Zero
);

  localparam int SHAMT_W = $clog2(DATA_W);
  localparam int HALF_W  = DATA_W / 2;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_ADD  = 4'd2,
    OP_SLL  = 4'd3,
    OP_SRL  = 4'd4,
    OP_SUB  = 4'd6,
    OP_SLT  = 4'd7,
    OP_ADDU = 4'd8,
    OP_SUBU = 4'd9,
    OP_XOR  = 4'd10,
    OP_SLTU = 4'd11,
    OP_NOR  = 4'd12,
    OP_SRA  = 4'd13,
    OP_LUI  = 4'd14
  } aluOp_e;

  logic signed [DATA_W-1:0] busASigned;
  logic signed [DATA_W-1:0] busBSigned;
  logic        [SHAMT_W-1:0] shamt;
  logic        [DATA_W-1:0] sumAB;
  logic        [DATA_W-1:0] diffAB;
  logic                     ltSigned;
  logic                     ltUnsigned;
  logic        [DATA_W-1:0] aluResult;

  assign busASigned = $signed(BusA);
  assign busBSigned = $signed(BusB);
  // Only the low bits of BusA select the shift distance; the rest is ignored.
  assign shamt      = BusA[SHAMT_W-1:0];

  // Signed and unsigned add/sub produce identical bits modulo 2^DATA_W; no
  // overflow or carry is reported, so one adder and one subtractor serve both.
  assign sumAB      = BusA + BusB;
  assign diffAB     = BusA - BusB;
  assign ltSigned   = (busASigned < busBSigned);
  assign ltUnsigned = (BusA < BusB);

  always_comb begin
    aluResult = '0;
    case (aluOp_e'(ALUCtrl))
      OP_AND:  aluResult = BusA & BusB;
      OP_OR:   aluResult = BusA | BusB;
      OP_ADD:  aluResult = sumAB;
      OP_SLL:  aluResult = BusB << shamt;
      OP_SRL:  aluResult = BusB >> shamt;
      OP_SUB:  aluResult = diffAB;
      OP_SLT:  aluResult = {{(DATA_W-1){1'b0}}, ltSigned};
      OP_ADDU: aluResult = sumAB;
      OP_SUBU: aluResult = diffAB;
      OP_XOR:  aluResult = BusA ^ BusB;
      OP_SLTU: aluResult = {{(DATA_W-1){1'b0}}, ltUnsigned};
      OP_NOR:  aluResult = ~(BusA | BusB);
      OP_SRA:  aluResult = DATA_W'(busBSigned >>> shamt);
      OP_LUI:  aluResult = {BusB[HALF_W-1:0], {HALF_W{1'b0}}};
      default: aluResult = '0;  // unassigned encodings 5 and 15
    endcase
  end

  // ---- stage boundary: combinational result -> registered BusW/Zero ----
  always_ff @(posedge Clk or negedge Resetb) begin
    if (!Resetb) begin
      BusW <= '0;
      Zero <= 1'b1;
    end else begin
      BusW <= aluResult;
      Zero <= (aluResult == '0);
    end
  end

endmodule

// File: tb/tb_alu.sv
module tb_alu;

  logic        Clk;
  logic        Resetb;
  logic [31:0] BusA;
  logic [31:0] BusB;
  logic [3:0]  ALUCtrl;
  logic [31:0] BusW;
  logic        Zero;

  int total = 0;
  int bad   = 0;

  alu #(.DATA_W(32)) dut (
    .Clk    (Clk),
    .Resetb (Resetb),
    .BusA   (BusA),
    .BusB   (BusB),
    .ALUCtrl(ALUCtrl),
    .BusW   (BusW),
    .Zero   (Zero)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one operation, let one rising edge capture it, then check both outputs.
  task automatic op(input string tag, input logic [3:0] ctl, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] expW, input logic expZ);
    ALUCtrl = ctl;
    BusA    = a;
    BusB    = b;
    @(posedge Clk);
    #1;
    chk({tag, ".W"}, BusW, expW);
    chk({tag, ".Z"}, {31'd0, Zero}, {31'd0, expZ});
  endtask

  initial begin
    Resetb  = 1'b0;
    BusA    = 32'h0;
    BusB    = 32'h0;
    ALUCtrl = 4'd0;

    // Reset state with the clock running
    @(posedge Clk); #1;
    chk("rst.W", BusW, 32'h0);
    chk("rst.Z", {31'd0, Zero}, 32'd1);
    ALUCtrl = 4'd1; BusA = 32'hDEAD_BEEF; BusB = 32'h1;
    @(posedge Clk); #1;
    chk("rstHold.W", BusW, 32'h0);
    Resetb = 1'b1;
    // Release lands between edges; nothing changes until the next edge
    #2;
    chk("relNoEdge.W", BusW, 32'h0);
    @(posedge Clk); #1;
    chk("relEdge.W", BusW, 32'hDEAD_BEEF);
    chk("relEdge.Z", {31'd0, Zero}, 32'd0);

    // Shifts
    op("srl",      4'd4,  32'd6,        32'hFFFF1234, 32'h03FFFC48, 1'b0);
    op("sraNeg",   4'd13, 32'd6,        32'hFFFF1234, 32'hFFFFFC48, 1'b0);
    op("sraPos",   4'd13, 32'd6,        32'h00001234, 32'h00000048, 1'b0);
    op("sraZero",  4'd13, 32'd3,        32'h00000001, 32'h00000000, 1'b1);
    op("sll",      4'd3,  32'd4,        32'h8000_00F1, 32'h0000_0F10, 1'b0);
    op("sllHiIgn", 4'd3,  32'hFFFF_FFE1, 32'h0000_0003, 32'h0000_0006, 1'b0);
    op("srlSh0",   4'd4,  32'h0000_0020, 32'hA5A5_0001, 32'hA5A5_0001, 1'b0);
    op("sraSh0",   4'd13, 32'h0000_0040, 32'h8000_0000, 32'h8000_0000, 1'b0);
    op("sraSh31",  4'd13, 32'd31,       32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Add / subtract
    op("adduZ",    4'd8,  32'h0,        32'h0,        32'h0,        1'b1);
    op("addu100",  4'd8,  32'hFF,       32'h1,        32'h100,      1'b0);
    op("adduMax",  4'd8,  32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    op("adduWrap", 4'd8,  32'hFFFFFFFF, 32'h2,        32'h1,        1'b0);
    op("addWrap",  4'd2,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0);
    op("subu2",    4'd9,  32'h1,        32'hFFFFFFFF, 32'h2,        1'b0);
    op("subuZ",    4'd9,  32'h1,        32'h1,        32'h0,        1'b1);
    op("subNeg",   4'd6,  32'h3,        32'h5,        32'hFFFFFFFE, 1'b0);

    // Logic
    op("and",      4'd0,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0);
    op("or",       4'd1,  32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b0);
    op("xor",      4'd10, 32'h12345678, 32'h87654321, 32'h95511559, 1'b0);
    op("nor",      4'd12, 32'hF0F0F0F0, 32'h0000FFFF, 32'h0F0F0000, 1'b0);

    // Compares
    op("sltuLt",   4'd11, 32'h0,        32'hFFFFFFFF, 32'h1,        1'b0);
    op("sltuGe",   4'd11, 32'hFFFFFFFF, 32'h0,        32'h0,        1'b1);
    op("sltNeg",   4'd7,  32'hFFFFFFFF, 32'h0,        32'h1,        1'b0);
    op("sltPos",   4'd7,  32'h0,        32'hFFFFFFFF, 32'h0,        1'b1);
    op("sltEq",    4'd7,  32'h5,        32'h5,        32'h0,        1'b1);

    // LUI and unassigned codes
    op("lui",      4'd14, 32'hFFFFFFFF, 32'h12345678, 32'h56780000, 1'b0);
    op("op5",      4'd5,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b1);
    op("op15",     4'd15, 32'h12345678, 32'h9ABCDEF0, 32'h0,        1'b1);

    // Latency: a new input is not visible until the following edge
    op("latA",     4'd8,  32'h10,       32'h20,       32'h30,       1'b0);
    ALUCtrl = 4'd8; BusA = 32'h1; BusB = 32'h1;
    #2;
    chk("latHold.W", BusW, 32'h30);
    @(posedge Clk); #1;
    chk("latNext.W", BusW, 32'h2);

    // Mid-stream asynchronous reset, no clock edge needed
    ALUCtrl = 4'd1; BusA = 32'hCAFE_0000; BusB = 32'h0000_F00D;
    @(posedge Clk); #1;
    chk("preRst.W", BusW, 32'hCAFE_F00D);
    #2;
    Resetb = 1'b0;
    #1;
    chk("asyncRst.W", BusW, 32'h0);
    chk("asyncRst.Z", {31'd0, Zero}, 32'd1);
    @(posedge Clk); #1;
    chk("rstEdge.W", BusW, 32'h0);
    #2;
    Resetb = 1'b1;
    ALUCtrl = 4'd10; BusA = 32'hFFFF_0000; BusB = 32'h0F0F_0F0F;
    #1;
    chk("postRel.W", BusW, 32'h0);
    @(posedge Clk); #1;
    chk("postRelEdge.W", BusW, 32'hF0F0_0F0F);
    chk("postRelEdge.Z", {31'd0, Zero}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
